// File: rtl/sys_clk_pkg.sv
// Shared constants for the MMCM clock/reset sequencer: state encoding,
// counter widths and default timing parameters.
package sys_clk_pkg;

   localparam int CNT_W   = 16;
   localparam int RETRY_W = 8;

   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_LOCK_TIMEOUT  = 65535;
   localparam int DEF_STABLE_CYCLES = 256;

   typedef enum logic [1:0] {
      ST_MMCM_RST  = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
      return (v == {RETRY_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear to 0 under the synchronous active-low reset.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/sys_clk_rst_ctrl.sv
// MMCM bring-up sequencer: pulses the MMCM reset, waits for a stable lock,
// then releases the system reset; re-pulses on timeout, lock loss or request.
module sys_clk_rst_ctrl
   import sys_clk_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               locked_i,
   input  logic               req_rst_i,
   output logic               mmcm_rst_o,
   output logic               sys_rst_n_o,
   output logic               ready_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   localparam logic [CNT_W-1:0] C_RST    = CNT_W'(RST_CYCLES);
   localparam logic [CNT_W-1:0] C_LOCK   = CNT_W'(LOCK_TIMEOUT);
   localparam logic [CNT_W-1:0] C_STABLE = CNT_W'(STABLE_CYCLES);

   logic               w_locked_s;
   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [RETRY_W-1:0] r_retry;
   logic               r_mmcm_rst;
   logic               r_ready;

   sync_2ff u_lock_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (locked_i),
      .q_o     (w_locked_s)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_MMCM_RST;
         r_cnt      <= C_RST;
         r_retry    <= '0;
         r_mmcm_rst <= 1'b1;
         r_ready    <= 1'b0;
      end else begin
         r_mmcm_rst <= 1'b0;
         r_ready    <= 1'b0;
         if (req_rst_i) begin
            r_state    <= ST_MMCM_RST;
            r_cnt      <= C_RST;
            r_mmcm_rst <= 1'b1;
         end else begin
            case (r_state)
               ST_MMCM_RST: begin
                  if (r_cnt <= 16'd1) begin
                     r_state <= ST_WAIT_LOCK;
                     r_cnt   <= C_LOCK;
                  end else begin
                     r_cnt      <= r_cnt - 1'b1;
                     r_mmcm_rst <= 1'b1;
                  end
               end
               ST_WAIT_LOCK: begin
                  if (w_locked_s) begin
                     r_state <= ST_STABLE;
                     r_cnt   <= C_STABLE;
                  end else if (r_cnt <= 16'd1) begin
                     r_state    <= ST_MMCM_RST;
                     r_cnt      <= C_RST;
                     r_mmcm_rst <= 1'b1;
                     r_retry    <= sat_inc(r_retry);
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               ST_STABLE: begin
                  // The lock-detect cycle in WAIT_LOCK is the first of the
                  // consecutive locked cycles, hence the exit at count 2.
                  if (!w_locked_s) begin
                     r_state <= ST_WAIT_LOCK;
                     r_cnt   <= C_LOCK;
                  end else if (r_cnt <= 16'd2) begin
                     r_state <= ST_RUN;
                  end else begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
               ST_RUN: begin
                  if (!w_locked_s) begin
                     r_state    <= ST_MMCM_RST;
                     r_cnt      <= C_RST;
                     r_mmcm_rst <= 1'b1;
                     r_retry    <= sat_inc(r_retry);
                  end else begin
                     r_ready <= 1'b1;
                  end
               end
               default: begin
                  r_state    <= ST_MMCM_RST;
                  r_cnt      <= C_RST;
                  r_mmcm_rst <= 1'b1;
               end
            endcase
         end
      end
   end

   assign mmcm_rst_o  = r_mmcm_rst;
   assign sys_rst_n_o = r_ready;
   assign ready_o     = r_ready;
   assign retry_cnt_o = r_retry;

endmodule

// File: tb/tb_sys_clk_rst_ctrl.sv
// Directed bench for sys_clk_rst_ctrl with a cycle-level behavioural model
// plus hand-computed latency and counter expectations.
module tb_sys_clk_rst_ctrl;

   localparam int P_RSTC = 4;
   localparam int P_TO   = 20;
   localparam int P_STAB = 8;

   localparam int M_RST    = 0;
   localparam int M_WAIT   = 1;
   localparam int M_STABLE = 2;
   localparam int M_RUN    = 3;

   logic       clk_i     = 1'b0;
   logic       rst_n_i   = 1'b0;
   logic       locked_i  = 1'b0;
   logic       req_rst_i = 1'b0;
   logic       mmcm_rst_o;
   logic       sys_rst_n_o;
   logic       ready_o;
   logic [7:0] retry_cnt_o;

   int n_vec = 0;
   int n_bad = 0;

   // model state
   int m_phase   = M_RST;
   int m_elapsed = 0;
   int m_lockrun = 0;
   int m_retry   = 0;
   int m_ready   = 0;
   int m_s1      = 0;
   int m_s2      = 0;

   sys_clk_rst_ctrl #(
      .RST_CYCLES    (P_RSTC),
      .LOCK_TIMEOUT  (P_TO),
      .STABLE_CYCLES (P_STAB)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .locked_i    (locked_i),
      .req_rst_i   (req_rst_i),
      .mmcm_rst_o  (mmcm_rst_o),
      .sys_rst_n_o (sys_rst_n_o),
      .ready_o     (ready_o),
      .retry_cnt_o (retry_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bump(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_edge();
      int ls;
      int prev;
      ls = m_s2;
      if (!rst_n_i) begin
         m_phase = M_RST; m_elapsed = 0; m_retry = 0; m_ready = 0;
         m_s1 = 0; m_s2 = 0;
      end else begin
         m_s2 = m_s1;
         m_s1 = int'(locked_i);
         prev = m_phase;
         if (req_rst_i) begin
            m_phase = M_RST; m_elapsed = 0;
         end else if (m_phase == M_RST) begin
            m_elapsed++;
            if (m_elapsed >= P_RSTC) begin m_phase = M_WAIT; m_elapsed = 0; end
         end else if (m_phase == M_WAIT) begin
            if (ls == 1) begin
               m_phase = M_STABLE; m_lockrun = 1;
            end else begin
               m_elapsed++;
               if (m_elapsed >= P_TO) begin
                  m_phase = M_RST; m_elapsed = 0; m_retry = bump(m_retry);
               end
            end
         end else if (m_phase == M_STABLE) begin
            if (ls == 0) begin
               m_phase = M_WAIT; m_elapsed = 0;
            end else begin
               m_lockrun++;
               if (m_lockrun >= P_STAB) m_phase = M_RUN;
            end
         end else begin
            if (ls == 0) begin
               m_phase = M_RST; m_elapsed = 0; m_retry = bump(m_retry);
            end
         end
         m_ready = (prev == M_RUN && m_phase == M_RUN) ? 1 : 0;
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      check("mmcm_rst_o", int'(mmcm_rst_o), (m_phase == M_RST) ? 1 : 0);
      check("sys_rst_n_o", int'(sys_rst_n_o), m_ready);
      check("ready_o", int'(ready_o), m_ready);
      check("retry_cnt_o", int'(retry_cnt_o), m_retry);
   endtask

   task automatic wait_ready(input logic val, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (ready_o !== val && n < 200);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end before 2ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int rises;
      logic prev;

      // reset state and release pulse
      rst_n_i = 1'b0;
      repeat (3) step();
      check("rst_mmcm", int'(mmcm_rst_o), 1);
      check("rst_sys_rst_n", int'(sys_rst_n_o), 0);
      check("rst_retry", int'(retry_cnt_o), 0);
      rst_n_i = 1'b1;
      n = 0;
      do begin step(); n++; end while (mmcm_rst_o && n < 50);
      check("release_pulse_len", n, 4);
      $display("[tb] reset release: mmcm_rst_o high %0d cycles", n);

      // first lock
      repeat (2) step();
      locked_i = 1'b1;
      wait_ready(1'b1, n);
      check("lock_to_ready", n, 11);
      check("first_lock_sys_rst_n", int'(sys_rst_n_o), 1);
      check("first_lock_retry", int'(retry_cnt_o), 0);
      $display("[tb] first lock: ready after %0d cycles", n);

      // lock loss in RUN
      locked_i = 1'b0;
      wait_ready(1'b0, n);
      check("loss_to_fall", n, 3);
      n = 0;
      while (mmcm_rst_o === 1'b1 && n < 50) begin step(); n++; end
      check("loss_pulse_len", n, 4);
      check("loss_retry", int'(retry_cnt_o), 1);
      locked_i = 1'b1;
      wait_ready(1'b1, n);
      check("relock_ready", int'(ready_o), 1);
      $display("[tb] lock loss: retry=%0d", retry_cnt_o);

      // request from RUN, then a 1-cycle lock glitch during STABLE
      req_rst_i = 1'b1;
      step();
      req_rst_i = 1'b0;
      check("req_ready_fall", int'(ready_o), 0);
      n = 0;
      do begin step(); n++; end while (mmcm_rst_o && n < 50);
      check("req_pulse_len", n, 4);
      repeat (2) step();
      locked_i = 1'b0;
      step();
      locked_i = 1'b1;
      wait_ready(1'b1, n);
      check("glitch_restart_latency", n, 11);
      check("glitch_retry", int'(retry_cnt_o), 1);
      $display("[tb] stable glitch: ready %0d cycles after relock", n);

      // 1-cycle reset in RUN, then 60 cycles without lock
      rst_n_i = 1'b0;
      step();
      check("midrst_mmcm", int'(mmcm_rst_o), 1);
      check("midrst_ready", int'(ready_o), 0);
      check("midrst_sys_rst_n", int'(sys_rst_n_o), 0);
      check("midrst_retry", int'(retry_cnt_o), 0);
      rst_n_i  = 1'b1;
      locked_i = 1'b0;
      rises = 0;
      prev  = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step();
         if (mmcm_rst_o && !prev) rises++;
         prev = mmcm_rst_o;
      end
      check("timeout_pulses", rises, 2);
      check("timeout_retry", int'(retry_cnt_o), 2);
      $display("[tb] no lock 60 cycles: %0d re-pulses", rises);

      // request coinciding with timeout, then again during MMCM reset
      repeat (11) step();
      req_rst_i = 1'b1;
      step();
      req_rst_i = 1'b0;
      check("req_vs_timeout_retry", int'(retry_cnt_o), 2);
      repeat (2) step();
      req_rst_i = 1'b1;
      step();
      req_rst_i = 1'b0;
      n = 0;
      while (mmcm_rst_o === 1'b1 && n < 50) begin step(); n++; end
      check("req_restart_pulse_len", n, 4);
      check("req_restart_retry", int'(retry_cnt_o), 2);
      $display("[tb] requests: pulse %0d cycles after last request", n);

      // saturation
      locked_i = 1'b1;
      wait_ready(1'b1, n);
      for (int i = 0; i < 300; i++) begin
         locked_i = 1'b0;
         wait_ready(1'b0, n);
         locked_i = 1'b1;
         wait_ready(1'b1, n);
      end
      check("sat_ready", int'(ready_o), 1);
      check("sat_retry", int'(retry_cnt_o), 255);
      $display("[tb] 300 losses: retry=%0d", retry_cnt_o);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
